maze_player: RTL and testbench
==============================

MAZE_PLAYER -- requirements
Module: maze_player

Interface
REQ-001 Parameter ROM_LATENCY, default 2, cycles from maprom addr/chipsel change to valid data (maprom has a ROM stage plus an output register).
REQ-002 Parameter GOAL_X, default 7, goal column; parameter GOAL_Y, default 7, goal row.
REQ-003 Ports, one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock shared with maprom
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begin loading level
- level  in  2  level select 0..2, sampled with start
- map_chipsel  out  2  to maprom chipsel
- map_addr  out  3  to maprom addr
- map_data  in  8  from maprom data
- move  in  4  one-hot request {up,down,left,right} = bits [3:0]
- move_ack  out  1  one-cycle pulse, move evaluated
- move_blocked  out  1  valid with move_ack, move refused
- pos_x  out  3  player column
- pos_y  out  3  player row
- busy  out  1  high in LOAD
- playing  out  1  high in PLAY
- win  out  1  high in WIN
- disp_sel  in  3  display row select
- disp_row  out  8  buffered row disp_sel, combinational read
- move_count  out  8  moves taken (MAZE_MOVE_COUNT_EN only)

Function
REQ-004 States IDLE, LOAD, PLAY, WIN; one-hot outputs busy/playing/win reflect LOAD/PLAY/WIN.
REQ-005 start with level<=2 in any state: latch level to map_chipsel, pos to (0,0), enter LOAD next cycle; start with level==3 ignored.
REQ-006 LOAD: map_addr steps 0..7 on consecutive cycles; map_chipsel held constant for the whole LOAD.
REQ-007 Row k captured into 8x8 buffer ROM_LATENCY cycles after map_addr==k; LOAD lasts exactly 8+ROM_LATENCY cycles, then PLAY.
REQ-008 Buffer bit convention: row y bit x (bit 0 = column 0), 1 = wall; row y=0 top, up decrements y.
REQ-009 move ignored outside PLAY and when not exactly one bit set (no ack).
REQ-010 Valid move in PLAY: cycle after request, move_ack=1; move_blocked=1 if target off-grid (no wrap) or target cell is wall; else pos updates same edge as move_ack.
REQ-011 Requests while move_ack high are accepted normally (one move per cycle throughput, latency 1).
REQ-012 Unblocked move landing on (GOAL_X,GOAL_Y): state WIN on the same edge as pos update; WIN holds until start or rst.
REQ-013 start simultaneous with move: start wins, move dropped, no ack.
REQ-014 start during LOAD restarts LOAD from addr 0 with new level; partially loaded rows overwritten.
REQ-015 Starting cell wall content not checked; player is placed at (0,0) regardless.
REQ-016 disp_row valid in all states; contents undefined-but-stable until first LOAD completes (cleared by reset, see REQ-018).

Reset
REQ-017 rst high on a clock edge: state IDLE, map_chipsel=0, map_addr=0, pos_x=pos_y=0, move_ack=move_blocked=0, busy=playing=win=0, move_count=0.
REQ-018 rst clears the row buffer to 0; rst mid-LOAD or mid-PLAY aborts with no partial-state carryover; rst dominates start.

Configuration
REQ-019 Macro MAZE_MOVE_COUNT_EN defined: move_count port present; increments on each acked unblocked move, saturates at 255, clears on start and rst.
REQ-020 Macro undefined: move_count port and counter absent; all other behaviour identical.

Verification
REQ-021 rst, start level=1, ROM_LATENCY=2 -> busy high 10 cycles, map_addr 0..7, map_chipsel=1 throughout, then playing=1, disp_row matches level-1 ROM rows 0..7.
REQ-022 PLAY at (0,0), move=up (4'b1000) -> move_ack=1, move_blocked=1, pos stays (0,0).
REQ-023 Row 0 = 8'h02, move=right -> blocked; row 0 = 8'h00, move=right -> pos (1,0), move_count=1 (with MAZE_MOVE_COUNT_EN).
REQ-024 Path to (7,7) -> win=1, playing=0; further move -> no move_ack; start level=2 -> busy, pos (0,0), move_count=0.
REQ-025 start level=3 in IDLE -> stays IDLE; move=4'b0011 in PLAY -> no ack; start and move same cycle -> LOAD, no ack.
REQ-026 rst asserted on 4th LOAD cycle -> next cycle IDLE, all outputs at reset values, disp_row=0 for all disp_sel.

Source files
------------

// File: rtl/maze_player.sv
// maze_player: loads an 8x8 wall map from an external ROM and lets a player
// step around it one cell per request until the goal cell is reached.
// Optional build macro MAZE_MOVE_COUNT_EN adds the move_count port and a
// saturating counter of successful moves.
module maze_player #(
    parameter int ROM_LATENCY = 2,
    parameter int GOAL_X      = 7,
    parameter int GOAL_Y      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] level,
    output logic [1:0] map_chipsel,
    output logic [2:0] map_addr,
    input  logic [7:0] map_data,
    input  logic [3:0] move,
    output logic       move_ack,
    output logic       move_blocked,
    output logic [2:0] pos_x,
    output logic [2:0] pos_y,
    output logic       busy,
    output logic       playing,
    output logic       win,
    input  logic [2:0] disp_sel,
    output logic [7:0] disp_row
`ifdef MAZE_MOVE_COUNT_EN
    ,
    output logic [7:0] move_count
`endif
);

    localparam int LOAD_CYCLES = 8 + ROM_LATENCY;
    localparam int CNT_W       = $clog2(LOAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(ROM_LATENCY);
    localparam logic [2:0] GX = 3'(GOAL_X);
    localparam logic [2:0] GY = 3'(GOAL_Y);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_WIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       chipsel_q, chipsel_d;
    logic [2:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_x_q, pos_x_d;
    logic [2:0]       pos_y_q, pos_y_d;
    logic             ack_q, ack_d;
    logic             blocked_q, blocked_d;
    logic [7:0]       row_buf_q [8];
    logic             row_wen;
    logic [2:0]       row_wsel;
`ifdef MAZE_MOVE_COUNT_EN
    logic [7:0]       count_q, count_d;
`endif

    logic       start_ok;
    logic       move_valid;
    logic [2:0] tgt_x, tgt_y;
    logic       off_grid;
    logic       tgt_wall;

    assign start_ok   = start && (level != 2'd3);
    assign move_valid = $onehot(move);

    // Target cell of the requested move; edges of the grid do not wrap.
    always_comb begin
        tgt_x    = pos_x_q;
        tgt_y    = pos_y_q;
        off_grid = 1'b0;
        case (move)
            4'b1000: if (pos_y_q == 3'd0) off_grid = 1'b1; else tgt_y = pos_y_q - 3'd1;
            4'b0100: if (pos_y_q == 3'd7) off_grid = 1'b1; else tgt_y = pos_y_q + 3'd1;
            4'b0010: if (pos_x_q == 3'd0) off_grid = 1'b1; else tgt_x = pos_x_q - 3'd1;
            4'b0001: if (pos_x_q == 3'd7) off_grid = 1'b1; else tgt_x = pos_x_q + 3'd1;
            default: ;
        endcase
        tgt_wall = row_buf_q[tgt_y][tgt_x];
    end

    // Next-state logic: start overrides everything, then per-state behaviour.
    always_comb begin
        state_d   = state_q;
        chipsel_d = chipsel_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        ack_d     = 1'b0;
        blocked_d = 1'b0;
        row_wen   = 1'b0;
        row_wsel  = 3'(cnt_q - CNT_LAT);
`ifdef MAZE_MOVE_COUNT_EN
        count_d   = count_q;
`endif
        if (start_ok) begin
            state_d   = S_LOAD;
            chipsel_d = level;
            addr_d    = 3'd0;
            cnt_d     = '0;
            pos_x_d   = 3'd0;
            pos_y_d   = 3'd0;
`ifdef MAZE_MOVE_COUNT_EN
            count_d   = 8'd0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (addr_q != 3'd7) addr_d = addr_q + 3'd1;
                    // Data for row k arrives ROM_LATENCY cycles after its address.
                    if (cnt_q >= CNT_LAT) row_wen = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PLAY;
                        addr_d  = 3'd0;
                    end
                end
                S_PLAY: begin
                    if (move_valid) begin
                        ack_d = 1'b1;
                        if (off_grid || tgt_wall) begin
                            blocked_d = 1'b1;
                        end else begin
                            pos_x_d = tgt_x;
                            pos_y_d = tgt_y;
`ifdef MAZE_MOVE_COUNT_EN
                            if (count_q != 8'hFF) count_d = count_q + 8'd1;
`endif
                            if (tgt_x == GX && tgt_y == GY) state_d = S_WIN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and control registers; reset dominates start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chipsel_q <= 2'd0;
            addr_q    <= 3'd0;
            cnt_q     <= '0;
            pos_x_q   <= 3'd0;
            pos_y_q   <= 3'd0;
            ack_q     <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chipsel_q <= chipsel_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            ack_q     <= ack_d;
            blocked_q <= blocked_d;
        end
    end

`ifdef MAZE_MOVE_COUNT_EN
    // Successful-move counter, cleared by reset and by each new level.
    always_ff @(posedge clk) begin
        if (rst) count_q <= 8'd0;
        else     count_q <= count_d;
    end
    assign move_count = count_q;
`else
    // No move counter in this build.
`endif

    // Row buffer: one register per row so reset can clear the whole map.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row
            always_ff @(posedge clk) begin
                if (rst)                                row_buf_q[gi] <= 8'd0;
                else if (row_wen && row_wsel == 3'(gi)) row_buf_q[gi] <= map_data;
            end
        end
    endgenerate

    assign map_chipsel  = chipsel_q;
    assign map_addr     = addr_q;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign move_ack     = ack_q;
    assign move_blocked = blocked_q;
    assign busy         = (state_q == S_LOAD);
    assign playing      = (state_q == S_PLAY);
    assign win          = (state_q == S_WIN);
    assign disp_row     = row_buf_q[disp_sel];

endmodule

// File: tb/tb_maze_player.sv
// Bench for maze_player: ROM model on the map port, randomized moves checked
// against a cell-level model of the game rules.
`timescale 1ns/1ps
module tb_maze_player;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] level, map_chipsel;
    logic [2:0] map_addr, pos_x, pos_y, disp_sel;
    logic [7:0] map_data, disp_row;
    logic [3:0] move;
    logic       move_ack, move_blocked, busy, playing, win;
`ifdef MAZE_MOVE_COUNT_EN
    logic [7:0] move_count;
`endif

    always #5 clk = ~clk;

    maze_player #(.ROM_LATENCY(L), .GOAL_X(7), .GOAL_Y(7)) dut (
        .clk(clk), .rst(rst), .start(start), .level(level),
        .map_chipsel(map_chipsel), .map_addr(map_addr), .map_data(map_data),
        .move(move), .move_ack(move_ack), .move_blocked(move_blocked),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .playing(playing), .win(win),
        .disp_sel(disp_sel), .disp_row(disp_row)
`ifdef MAZE_MOVE_COUNT_EN
        , .move_count(move_count)
`endif
    );

    // External ROM: registered lookup followed by L-1 more register stages.
    logic [7:0] rom [4][8];
    logic [7:0] rom_pipe [L];
    always @(posedge clk) begin
        rom_pipe[0] <= rom[map_chipsel][map_addr];
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign map_data = rom_pipe[L-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Game model: 0 idle, 1 loading, 2 playing, 3 won.
    int         ms, mx, my, mlvl, mcnt, mcount;
    bit         mack, mblk;
    logic [7:0] mgrid [8];

    task automatic model_edge(input bit r, input bit s, input logic [1:0] lvl, input logic [3:0] mv);
        int tx, ty;
        if (r) begin
            ms = 0; mx = 0; my = 0; mack = 0; mblk = 0; mcount = 0; mcnt = 0; mlvl = 0;
            for (int k = 0; k < 8; k++) mgrid[k] = 8'd0;
        end else if (s && lvl != 2'd3) begin
            ms = 1; mlvl = int'(lvl); mcnt = 0; mx = 0; my = 0; mack = 0; mblk = 0; mcount = 0;
        end else begin
            mack = 0; mblk = 0;
            if (ms == 1) begin
                mcnt++;
                if (mcnt == 8 + L) begin
                    ms = 2;
                    for (int k = 0; k < 8; k++) mgrid[k] = rom[mlvl][k];
                end
            end else if (ms == 2 && $countones(mv) == 1) begin
                mack = 1; tx = mx; ty = my;
                if (mv[3])      ty = ty - 1;
                else if (mv[2]) ty = ty + 1;
                else if (mv[1]) tx = tx - 1;
                else            tx = tx + 1;
                if (tx < 0 || tx > 7 || ty < 0 || ty > 7) mblk = 1;
                else if (mgrid[ty][tx]) mblk = 1;
                else begin
                    mx = tx; my = ty;
                    if (mcount < 255) mcount++;
                    if (tx == 7 && ty == 7) ms = 3;
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare against the model.
    task automatic step(input bit r, input bit s, input logic [1:0] lvl, input logic [3:0] mv);
        rst = r; start = s; level = lvl; move = mv;
        @(posedge clk); #1;
        model_edge(r, s, lvl, mv);
        rst = 1'b0; start = 1'b0; move = 4'd0;
        chk("busy",    32'(busy),         32'(ms == 1));
        chk("playing", 32'(playing),      32'(ms == 2));
        chk("win",     32'(win),          32'(ms == 3));
        chk("pos_x",   32'(pos_x),        32'(mx));
        chk("pos_y",   32'(pos_y),        32'(my));
        chk("ack",     32'(move_ack),     32'(mack));
        chk("blocked", 32'(move_blocked), 32'(mblk));
        if (ms == 1) begin
            chk("chipsel", 32'(map_chipsel), 32'(mlvl));
            chk("addr",    32'(map_addr),    32'((mcnt < 8) ? mcnt : 7));
        end
`ifdef MAZE_MOVE_COUNT_EN
        chk("count", 32'(move_count), 32'(mcount));
`endif
        if (r || s || mv != 4'd0)
            $display("t=%0t rst=%0b start=%0b lvl=%0d move=%b -> pos=(%0d,%0d) ack=%0b blk=%0b st=%0d",
                     $time, r, s, lvl, mv, pos_x, pos_y, move_ack, move_blocked, ms);
    endtask

    task automatic chk_disp(input string tag);
        for (int i = 0; i < 8; i++) begin
            disp_sel = 3'(i);
            #1;
            chk(tag, 32'(disp_row), 32'(mgrid[i]));
        end
    endtask

    // Idle clocks until the model leaves LOAD; n counts cycles with busy high.
    task automatic wait_load(output int n);
        int guard;
        n = 0; guard = 0;
        while (ms == 1 && guard < 50) begin
            if (busy) n++;
            step(0, 0, 2'd0, 4'd0);
            guard++;
        end
        if (guard >= 50) chk("load_timeout", 32'(guard), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] mv;
        rst = 1'b1; start = 1'b0; level = 2'd0; move = 4'd0; disp_sel = 3'd0;
        ms = 0; mx = 0; my = 0; mlvl = 0; mcnt = 0; mcount = 0; mack = 0; mblk = 0;
        for (int k = 0; k < 8; k++) mgrid[k] = 8'd0;
        for (int lv = 0; lv < 4; lv++)
            for (int k = 0; k < 8; k++)
                rom[lv][k] = (lv == 3) ? 8'd0 : 8'($urandom_range(0, 255) & $urandom_range(0, 255));
        // Level 0: open top row and open right column give a path to the goal.
        rom[0][0] = 8'h00;
        for (int k = 0; k < 8; k++) rom[0][k][7] = 1'b0;
        rom[1][0] = 8'h02;
        for (int i = 0; i < L; i++) rom_pipe[i] = 8'd0;

        step(1, 0, 2'd0, 4'd0);
        step(1, 0, 2'd0, 4'd0);
        chk("rst_addr",    32'(map_addr),    32'(0));
        chk("rst_chipsel", 32'(map_chipsel), 32'(0));
        chk_disp("rst_disp");

        step(0, 1, 2'd3, 4'd0);                 // level 3 is ignored

        step(0, 1, 2'd1, 4'd0);
        wait_load(n);
        chk("load_len", 32'(n), 32'(8 + L));
        chk_disp("disp_l1");
        step(0, 0, 2'd0, 4'b1000);              // up off the top edge
        step(0, 0, 2'd0, 4'b0001);              // right into wall
        step(0, 0, 2'd0, 4'b0011);              // two bits: ignored
        step(0, 0, 2'd0, 4'b0000);

        step(0, 1, 2'd0, 4'b0001);              // start beats move
        repeat (3) step(0, 0, 2'd0, 4'd0);
        step(0, 1, 2'd2, 4'd0);                 // restart mid-load
        wait_load(n);
        chk("reload_len", 32'(n), 32'(8 + L));
        chk_disp("disp_l2");

        step(0, 1, 2'd0, 4'd0);
        wait_load(n);
        chk_disp("disp_l0");
        step(0, 0, 2'd0, 4'b0001);              // to (1,0)
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) != 0) mv = 4'(1 << $urandom_range(0, 3));
            else                           mv = 4'($urandom_range(0, 15));
            step(0, 0, 2'd0, mv);
        end

        step(0, 1, 2'd0, 4'd0);
        wait_load(n);
        repeat (7) step(0, 0, 2'd0, 4'b0001);
        repeat (7) step(0, 0, 2'd0, 4'b0100);
        chk("win_reached", 32'(win), 32'(1));
        step(0, 0, 2'd0, 4'b0100);
        step(0, 0, 2'd0, 4'b0010);

        step(0, 1, 2'd2, 4'd0);
        repeat (3) step(0, 0, 2'd0, 4'd0);
        step(1, 0, 2'd0, 4'd0);                 // reset in the 4th LOAD cycle
        chk("mid_rst_addr",    32'(map_addr),    32'(0));
        chk("mid_rst_chipsel", 32'(map_chipsel), 32'(0));
        chk_disp("mid_rst_disp");
        step(0, 0, 2'd0, 4'b0001);              // idle: no ack

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
